// File: rtl/bridge_gate_driver_if.sv
// Command, control and gate-drive signals between the clock source stage and the bridge gate driver.
interface bridge_gate_driver_if;
  logic Fsw;
  logic Fsw_bar;
  logic enable;
  logic fault;
  logic fault_clr;
  logic ga_hi;
  logic ga_lo;
  logic gb_hi;
  logic gb_lo;
  logic fault_latched;

  modport master (
    output Fsw, Fsw_bar, enable, fault, fault_clr,
    input  ga_hi, ga_lo, gb_hi, gb_lo, fault_latched
  );

  modport slave (
    input  Fsw, Fsw_bar, enable, fault, fault_clr,
    output ga_hi, ga_lo, gb_hi, gb_lo, fault_latched
  );
endinterface

// File: rtl/bridge_gate_driver.sv
// Dead-time-protected complementary gate driver for a two-leg phase-shifted full bridge with latched fault.
// Define GATE_MIN_ON_EN to hold each gate on for at least MIN_ON_CYCLES after it turns on.
module bridge_gate_driver #(
  parameter int DEAD_CYCLES   = 3,
  parameter int CNT_W         = 4,
  parameter int MIN_ON_CYCLES = 4
) (
  input logic                 clk,
  input logic                 reset,
  bridge_gate_driver_if.slave bus
);
  typedef enum logic [1:0] {SAFE, HI, LO, DT} leg_state_t;

  localparam logic [CNT_W-1:0] DT_LOAD = CNT_W'(DEAD_CYCLES - 1);
`ifdef GATE_MIN_ON_EN
  localparam logic [CNT_W-1:0] ON_LOAD = CNT_W'(MIN_ON_CYCLES - 1);
`else
  localparam logic [CNT_W-1:0] ON_LOAD = '0;
`endif

  generate
    if (DEAD_CYCLES < 1 || DEAD_CYCLES > 15 || DEAD_CYCLES > (1 << CNT_W) ||
        MIN_ON_CYCLES < 1 || MIN_ON_CYCLES > (1 << CNT_W)) begin : g_bad_param
      $error("bridge_gate_driver: DEAD_CYCLES/MIN_ON_CYCLES out of range for CNT_W");
    end
  endgenerate

  logic       fault_latched_reg;
  logic [1:0] cmd_reg;
  logic [1:0] gate_hi;
  logic [1:0] gate_lo;
  logic       force_safe;

  // A fresh fault clears the gates at the same edge it is latched, without waiting a cycle.
  assign force_safe = !bus.enable || fault_latched_reg || bus.fault;

  // Upstream commands come from a combinational loop, so they are registered before any use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_reg           <= '0;
      fault_latched_reg <= 1'b0;
    end else begin
      cmd_reg <= {bus.Fsw_bar, bus.Fsw};
      if (bus.fault)
        fault_latched_reg <= 1'b1;
      else if (bus.fault_clr)
        fault_latched_reg <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_leg
      leg_state_t       state_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             hi_reg;
      logic             lo_reg;
      logic             hold_done;

`ifdef GATE_MIN_ON_EN
      assign hold_done = (cnt_reg == '0);
`else
      assign hold_done = 1'b1;
`endif

      // One counter serves both the dead-time in DT and the optional min-on hold in HI/LO.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_reg <= SAFE;
          cnt_reg   <= '0;
          hi_reg    <= 1'b0;
          lo_reg    <= 1'b0;
        end else if (force_safe) begin
          state_reg <= SAFE;
          cnt_reg   <= '0;
          hi_reg    <= 1'b0;
          lo_reg    <= 1'b0;
        end else begin
          case (state_reg)
            SAFE: begin
              state_reg <= DT;
              cnt_reg   <= DT_LOAD;
              hi_reg    <= 1'b0;
              lo_reg    <= 1'b0;
            end
            HI: begin
              if (!cmd_reg[gi] && hold_done) begin
                state_reg <= DT;
                cnt_reg   <= DT_LOAD;
                hi_reg    <= 1'b0;
              end else if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
              end
            end
            LO: begin
              if (cmd_reg[gi] && hold_done) begin
                state_reg <= DT;
                cnt_reg   <= DT_LOAD;
                lo_reg    <= 1'b0;
              end else if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
              end
            end
            DT: begin
              if (cnt_reg == '0) begin
                state_reg <= cmd_reg[gi] ? HI : LO;
                cnt_reg   <= ON_LOAD;
                hi_reg    <= cmd_reg[gi];
                lo_reg    <= !cmd_reg[gi];
              end else begin
                cnt_reg <= cnt_reg - CNT_W'(1);
              end
            end
            default: begin
              state_reg <= SAFE;
              cnt_reg   <= '0;
              hi_reg    <= 1'b0;
              lo_reg    <= 1'b0;
            end
          endcase
        end
      end

      assign gate_hi[gi] = hi_reg;
      assign gate_lo[gi] = lo_reg;
    end
  endgenerate

  assign bus.ga_hi         = gate_hi[0];
  assign bus.ga_lo         = gate_lo[0];
  assign bus.gb_hi         = gate_hi[1];
  assign bus.gb_lo         = gate_lo[1];
  assign bus.fault_latched = fault_latched_reg;
endmodule

// File: tb/tb_bridge_gate_driver.sv
// Directed bench for bridge_gate_driver with DEAD_CYCLES=3; observed word is
// {fault_latched, ga_hi, ga_lo, gb_hi, gb_lo}, sampled 1 ns after each rising edge.
module tb_bridge_gate_driver;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bridge_gate_driver_if bus();

  bridge_gate_driver #(
    .DEAD_CYCLES  (3),
    .CNT_W        (4),
    .MIN_ON_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] observed();
    return {bus.fault_latched, bus.ga_hi, bus.ga_lo, bus.gb_hi, bus.gb_lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check5(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic steps(input int n, input logic [4:0] exp, input string tag);
    repeat (n) begin
      tick();
      check5(tag, exp);
    end
  endtask

  // Square-wave command with a 100-cycle period, high for the first half.
  function automatic logic fsw_level(input int k);
    if (k < 0) return 1'b1;
    return (((k + 50) / 50) % 2) == 1;
  endfunction

  // Expected {hi, lo} after edge m: a command change driven after edge j
  // blanks both gates on edges j+2..j+4 and the new level appears at j+5.
  function automatic logic [1:0] leg_expect(input int m, input int lag);
    logic c0, c1, c2, c3;
    c0 = fsw_level(m - 2 - lag);
    c1 = fsw_level(m - 3 - lag);
    c2 = fsw_level(m - 4 - lag);
    c3 = fsw_level(m - 5 - lag);
    if (c0 != c1 || c1 != c2 || c2 != c3) return 2'b00;
    return {c0, ~c0};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      assert (!(bus.ga_hi && bus.ga_lo) && !(bus.gb_hi && bus.gb_lo)) else begin
        errors++;
        $error("FAIL overlap: ga=%b%b gb=%b%b expected no hi&lo pair",
               bus.ga_hi, bus.ga_lo, bus.gb_hi, bus.gb_lo);
      end
    end
  end

  initial begin
    bus.Fsw       = 1'b0;
    bus.Fsw_bar   = 1'b0;
    bus.enable    = 1'b0;
    bus.fault     = 1'b0;
    bus.fault_clr = 1'b0;

    repeat (3) tick();
    check5("reset", 5'b00000);
    reset = 1'b0;
    steps(1, 5'b00000, "post_reset");

    // Power-up into LO on both legs
    bus.enable = 1'b1;
    steps(3, 5'b00000, "pwrup_dt");
    steps(1, 5'b00101, "pwrup_lo");
    steps(4, 5'b00101, "pwrup_hold");

    // Steady toggle of leg A, low to high and back
    bus.Fsw = 1'b1;
    steps(1, 5'b00101, "tog_up_e0");
    steps(3, 5'b00001, "tog_up_dt");
    steps(1, 5'b01001, "tog_up_hi");
    steps(4, 5'b01001, "tog_up_hold");
    bus.Fsw = 1'b0;
    steps(1, 5'b01001, "tog_dn_e0");
    steps(3, 5'b00001, "tog_dn_dt");
    steps(1, 5'b00101, "tog_dn_lo");
    steps(4, 5'b00101, "tog_dn_hold");

    // One-cycle glitch while leg A sits in LO
    bus.Fsw = 1'b1;
    steps(1, 5'b00101, "glitch_e0");
    bus.Fsw = 1'b0;
    steps(3, 5'b00001, "glitch_dt");
    steps(1, 5'b00101, "glitch_lo");
    steps(4, 5'b00101, "glitch_hold");

    // Both legs to HI, then a two-cycle fault
    bus.Fsw     = 1'b1;
    bus.Fsw_bar = 1'b1;
    steps(1, 5'b00101, "both_e0");
    steps(3, 5'b00000, "both_dt");
    steps(1, 5'b01010, "both_hi");
    steps(4, 5'b01010, "both_hold");
    bus.fault = 1'b1;
    steps(1, 5'b10000, "fault_set");
    bus.fault_clr = 1'b1;
    steps(1, 5'b10000, "fault_clr_ignored");
    bus.fault     = 1'b0;
    bus.fault_clr = 1'b0;
    steps(2, 5'b10000, "fault_sticky");
    bus.fault_clr = 1'b1;
    steps(1, 5'b00000, "fault_clr");
    bus.fault_clr = 1'b0;
    steps(3, 5'b00000, "resume_dt");
    steps(1, 5'b01010, "resume_hi");
    steps(4, 5'b01010, "resume_hold");

    // Leg B lags leg A by 5 cycles on a 100-cycle period
    for (int k = 0; k < 215; k++) begin
      bus.Fsw     = fsw_level(k);
      bus.Fsw_bar = fsw_level(k - 5);
      tick();
      check5("phase", {1'b0, leg_expect(k + 1, 0), leg_expect(k + 1, 5)});
    end

    // One-cycle enable drop
    bus.enable = 1'b0;
    steps(1, 5'b00000, "en_off");
    bus.enable = 1'b1;
    steps(3, 5'b00000, "en_dt");
    steps(1, 5'b01010, "en_hi");
    steps(4, 5'b01010, "en_hold");

    // Leg A to LO, then a short high pulse of the command after ga_hi rises
    bus.Fsw = 1'b0;
    steps(1, 5'b01010, "pre_e0");
    steps(3, 5'b00010, "pre_dt");
    steps(1, 5'b00110, "pre_lo");
    steps(4, 5'b00110, "pre_hold");
    bus.Fsw = 1'b1;
    steps(1, 5'b00110, "short_e0");
    steps(3, 5'b00010, "short_dt");
    steps(1, 5'b01010, "short_hi");
    bus.Fsw = 1'b0;
`ifdef GATE_MIN_ON_EN
    steps(3, 5'b01010, "minon_hold");
    steps(3, 5'b00010, "minon_dt");
    steps(1, 5'b00110, "minon_lo");
`else
    steps(1, 5'b01010, "quick_e0");
    steps(3, 5'b00010, "quick_dt");
    steps(1, 5'b00110, "quick_lo");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bridge_gate_driver.md
Name: bridge_gate_driver

Overview:
- Consumes the two switching clocks Fsw and Fsw_bar from the clock source stage.
- Produces dead-time-protected complementary gate pairs for a two-leg, phase-shifted full bridge: leg A follows Fsw and leg B follows Fsw_bar.
- Adds an enable path and a latched fault shutdown, so no leg can ever drive its high and low gates together.

Parameters:
- DEAD_CYCLES, 3: clk cycles during which both gates of a leg are low between complementary transitions. Legal range 1..15; 0 is a compile-time error.
- CNT_W, 4: width of the dead-time and min-on counters.
- MIN_ON_CYCLES, 4: minimum gate on-time in clk cycles. Used only when GATE_MIN_ON_EN is defined.

Ports:
- clk  input  1  system clock, same clock as the clock source stage.
- reset  input  1  asynchronous, active-high reset.
- Fsw  input  1  leg A command (1 = high-side on, 0 = low-side on).
- Fsw_bar  input  1  leg B command, same encoding.
- enable  input  1  synchronous enable; 0 forces all gates low.
- fault  input  1  synchronous fault from the power stage, active-high.
- fault_clr  input  1  single-cycle request to clear the latched fault.
- ga_hi  output  1  leg A high-side gate.
- ga_lo  output  1  leg A low-side gate.
- gb_hi  output  1  leg B high-side gate.
- gb_lo  output  1  leg B low-side gate.
- fault_latched  output  1  sticky fault status.

Behaviour:
- Reset (asynchronous, active-high): all gate outputs 0, fault_latched 0, command registers 0, both leg FSMs in SAFE.
- Input stage: Fsw and Fsw_bar are each registered once (cmd_a, cmd_b) before use, because the upstream outputs come from a combinational loop. All outputs are registered.
- Each leg runs an identical, independent FSM.
  - SAFE: both gates 0. Go to DT on an edge where enable=1 and fault_latched=0.
  - HI: hi gate 1, lo gate 0. Go to DT when the registered command is 0.
  - LO: lo gate 1, hi gate 0. Go to DT when the registered command is 1.
  - DT: both gates 0. Counter loads DEAD_CYCLES-1 on entry and decrements each cycle. On the edge after the counter reaches 0, go to HI if the registered command is 1, otherwise LO.
- DT always completes in full, even if the command reverts during it. A command that reverts during DT returns the leg to its prior state through a full dead-time.
- Latency: a command change before edge E0 is captured at E0. The active gate falls at E1. The complementary gate rises at E1+DEAD_CYCLES.
- Any state goes to SAFE at the next edge when enable=0 or fault_latched=1. On leaving SAFE the leg always passes through DT, so gates never turn on directly from SAFE.
- Fault handling:
  - fault_latched sets at the first edge where fault=1.
  - All four gate registers clear at that same edge; they do not wait for the FSM.
  - fault_clr clears fault_latched only on an edge where fault=0. If fault and fault_clr are both 1, fault wins.
- Invariants: (ga_hi & ga_lo) and (gb_hi & gb_lo) are never 1. Every complementary transition within a leg has at least DEAD_CYCLES cycles with both gates low.
- Legs A and B share only enable and the fault logic; any phase offset between Fsw and Fsw_bar passes through unchanged.

Optional Feature:
- Macro GATE_MIN_ON_EN.
- Defined: HI and LO each hold for at least MIN_ON_CYCLES after entry, even if the command changes earlier. A command change arriving earlier is acted on when the hold expires, provided it is still present. Fault and enable=0 still override the hold immediately.
- Undefined: no min-on counter is built, and HI/LO exit as soon as the command changes.

Test Plan (DEAD_CYCLES=3):
- Power-up: reset pulse, then enable=1, Fsw=0 → leg A goes SAFE→DT, 3 cycles with both gates low, then ga_lo=1 on the edge 4 cycles after the enable edge; ga_hi stays 0.
- Steady toggle: Fsw 0→1 before E0 → ga_lo falls at E1, ga_hi rises at E4. The reverse transition is symmetric. Check the overlap assertion every cycle.
- Glitch: Fsw high for exactly 1 cycle while leg A is in LO → ga_lo low for 3 cycles, then ga_lo returns to 1; ga_hi never asserts.
- Fault mid-HI: fault=1 for 2 cycles → all gates 0 and fault_latched=1 at the first edge. fault_clr pulsed with fault=1 is ignored. fault_clr pulsed with fault=0 clears the latch; legs then pass through DT for 3 cycles and resume following Fsw/Fsw_bar.
- Phase shift: Fsw_bar lags Fsw by 5 cycles with a 100-cycle period → gb_* waveforms equal ga_* delayed by 5 cycles; enable=0 for 1 cycle forces all four gates low at the next edge, followed by a DT restart.
- GATE_MIN_ON_EN with MIN_ON_CYCLES=4: Fsw falls 1 cycle after ga_hi rises → ga_hi held for 4 cycles, then a 3-cycle dead-time, then ga_lo=1.
